// File: rtl/sar_search_pkg.sv
// rtl/sar_search_pkg.sv - shared types and constants for the successive-approximation search controller
package sar_search_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TEST = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sar_search_if.sv
// rtl/sar_search_if.sv - start/comparator/result bundle between the search controller and its environment
interface sar_search_if #(
  parameter int WIDTH = sar_search_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             err;

  // master: the search controller; slave: requester plus external comparator
  modport master (
    input  start, gt, lt, eq,
    output trial, result, busy, done, err
  );

  modport slave (
    output start, gt, lt, eq,
    input  trial, result, busy, done, err
  );

endinterface

// File: rtl/sar_search.sv
// rtl/sar_search.sv - MSB-first successive-approximation search driving an external magnitude comparator
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic         clk,
  input logic         rst_n,
  sar_search_if.master bus
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONLY = WIDTH'(1) << (WIDTH - 1);
  localparam logic [KW-1:0]    K_TOP    = KW'(WIDTH - 1);

  state_t           state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] trial_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] trial_kept;
  logic [WIDTH-1:0] trial_next;
  logic             fb_onehot;

  // Decision for the current bit, then tentatively set the next lower bit.
  always_comb begin
    bit_k      = WIDTH'(1) << k;
    trial_kept = bus.lt ? (trial_q & ~bit_k) : trial_q;
    trial_next = trial_kept | (bit_k >> 1);
    fb_onehot  = $onehot({bus.gt, bus.lt, bus.eq});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      k        <= K_TOP;
      trial_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            trial_q  <= MSB_ONLY;
            k        <= K_TOP;
            err_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state    <= ST_TEST;
          end else begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_TEST: begin
          if (!fb_onehot) begin
            err_q    <= 1'b1;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= ST_DONE;
          end else if (bus.eq) begin
            result_q <= trial_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= ST_DONE;
          end else if (k == '0) begin
            trial_q  <= trial_kept;
            result_q <= trial_kept;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= ST_DONE;
          end else begin
            trial_q <= trial_next;
            k       <= k - 1'b1;
          end
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.trial  = trial_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule
